// File: rtl/imem_if.sv
// Instruction-memory read bus between the fetch stage (master) and the
// instruction memory (slave).
//   imem_req   : read request, held with imem_addr until imem_ack
//   imem_addr  : word address of the read (bits [1:0] always zero)
//   imem_ack   : read data valid / transaction complete
//   imem_rdata : read data, meaningful only while imem_ack is high
interface imem_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage of the RockWave core.
// Holds the PC and issues one instruction-memory read for each phase_fetch
// strobe. The fetched word is registered, together with its PC and PC+4,
// for the decode stage. A redirect (pc_load) may arrive at any time. If a
// read is outstanding, that read is still completed on the bus, but its
// data is discarded and a NOP is delivered in its place.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   phase_fetch    : fetch start strobe from the sequencer
//   pc_load        : PC redirect request
//   pc_load_addr   : redirect target (low two bits dropped)
//   imem           : instruction-memory read bus (master side)
//   inst           : fetched instruction to decode
//   curr_pc_fd     : PC of inst
//   next_pc_fd     : curr_pc_fd + 4
//   stall_fetch    : fetch in progress, the sequencer holds its phase
module instruction_fetch #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]     NOP_INST     = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            phase_fetch,
  input  logic            pc_load,
  input  logic [XLEN-1:0] pc_load_addr,
  imem_if.master          imem,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic [XLEN-1:0] next_pc_fd,
  output logic            stall_fetch
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [XLEN-1:0] WORD_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [0:0]      state;
  logic            kill;
  logic [XLEN-1:0] pc_p0;
  logic            req_p0;
  logic [XLEN-1:0] addr_p0;
  logic [XLEN-1:0] load_tgt;
  logic            ack_in_wait;

  // Redirect targets are forced to a word boundary; there is no
  // misalignment trap.
  assign load_tgt    = pc_load_addr & ALIGN_MASK;
  assign ack_in_wait = (state == WAIT) && imem.imem_ack;

  assign imem.imem_req  = req_p0;
  assign imem.imem_addr = addr_p0;

  // The fetch stalls in the request cycle and in every cycle it waits for
  // memory. It is not stalled in the ack cycle, so a latency of N gives
  // exactly N stall cycles.
  assign stall_fetch = ((state == IDLE) && phase_fetch) ||
                       ((state == WAIT) && !imem.imem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      kill       <= 1'b0;
      pc_p0      <= RESET_VECTOR;
      req_p0     <= 1'b0;
      addr_p0    <= RESET_VECTOR;
      inst       <= NOP_INST;
      curr_pc_fd <= RESET_VECTOR;
      next_pc_fd <= RESET_VECTOR + WORD_STEP;
    end else begin
      // Stage p0: issue the read from the current PC.
      if ((state == IDLE) && phase_fetch) begin
        state   <= WAIT;
        req_p0  <= 1'b1;
        addr_p0 <= pc_p0;
        // A redirect in the issue cycle still lets the read go out from the
        // old PC, but the read is marked dead.
        if (pc_load) begin
          kill <= 1'b1;
        end
      end else if ((state == WAIT) && !imem.imem_ack && pc_load) begin
        kill <= 1'b1;
      end

      // Stage p1: retire the read into the decode-facing registers.
      if (ack_in_wait) begin
        state  <= IDLE;
        req_p0 <= 1'b0;
        kill   <= 1'b0;
        if (kill || pc_load) begin
          inst <= NOP_INST;
        end else begin
          inst       <= imem.imem_rdata;
          curr_pc_fd <= addr_p0;
          next_pc_fd <= addr_p0 + WORD_STEP;
          pc_p0      <= addr_p0 + WORD_STEP;
        end
      end

      // A redirect wins over the sequential increment.
      if (pc_load) begin
        pc_p0 <= load_tgt;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        phase_fetch;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic [31:0] inst;
  logic [31:0] curr_pc_fd;
  logic [31:0] next_pc_fd;
  logic        stall_fetch;

  int total;
  int bad;

  imem_if #(.XLEN(32)) imem ();

  instruction_fetch #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .phase_fetch(phase_fetch),
    .pc_load(pc_load),
    .pc_load_addr(pc_load_addr),
    .imem(imem.master),
    .inst(inst),
    .curr_pc_fd(curr_pc_fd),
    .next_pc_fd(next_pc_fd),
    .stall_fetch(stall_fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Single-wait-state fetch: strobe, ack in the next cycle, then check the
  // decode-facing outputs.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                          input logic [31:0] rd);
    phase_fetch = 1'b1;
    #2 chk({tag, "_stall_T"}, 32'(stall_fetch), 32'd1);
    cyc();
    phase_fetch     = 1'b0;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = rd;
    #2;
    chk({tag, "_req"}, 32'(imem.imem_req), 32'd1);
    chk({tag, "_addr"}, imem.imem_addr, exp_addr);
    chk({tag, "_stall_ack"}, 32'(stall_fetch), 32'd0);
    cyc();
    imem.imem_ack = 1'b0;
    #2;
    chk({tag, "_req_done"}, 32'(imem.imem_req), 32'd0);
    chk({tag, "_inst"}, inst, rd);
    chk({tag, "_curr"}, curr_pc_fd, exp_addr);
    chk({tag, "_next"}, next_pc_fd, exp_addr + 32'd4);
    cyc();
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst_n           = 1'b0;
    phase_fetch     = 1'b0;
    pc_load         = 1'b0;
    pc_load_addr    = '0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;

    // Reset, then idle.
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    #2;
    chk("rst_req", 32'(imem.imem_req), 32'd0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_curr", curr_pc_fd, 32'h0);
    chk("rst_next", next_pc_fd, 32'h4);
    chk("rst_stall", 32'(stall_fetch), 32'd0);
    cyc();

    // A stray ack while idle must be ignored.
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hBAD0_BAD0;
    cyc();
    imem.imem_ack = 1'b0;
    #2 chk("idle_ack_inst", inst, 32'h0000_0013);
    cyc();

    // Back-to-back minimum-latency fetches.
    do_fetch("f0", 32'h0, 32'h0050_0093);
    do_fetch("f1", 32'h4, 32'h00A0_0113);

    // Three-cycle latency, with extra strobes while waiting.
    phase_fetch = 1'b1;
    cyc();
    for (int i = 0; i < 2; i++) begin
      phase_fetch = (i == 0);
      #2;
      chk("slow_req", 32'(imem.imem_req), 32'd1);
      chk("slow_addr", imem.imem_addr, 32'h8);
      chk("slow_stall", 32'(stall_fetch), 32'd1);
      cyc();
    end
    phase_fetch     = 1'b0;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h0010_8193;
    #2 chk("slow_stall_ack", 32'(stall_fetch), 32'd0);
    cyc();
    imem.imem_ack = 1'b0;
    #2;
    chk("slow_inst", inst, 32'h0010_8193);
    chk("slow_curr", curr_pc_fd, 32'h8);
    chk("slow_next", next_pc_fd, 32'hC);
    cyc();
    #2 chk("slow_no_requeue", 32'(imem.imem_req), 32'd0);
    cyc();

    // Redirect while waiting; the read is completed but discarded.
    phase_fetch = 1'b1;
    cyc();
    phase_fetch  = 1'b0;
    pc_load      = 1'b1;
    pc_load_addr = 32'h0000_0102;
    cyc();
    pc_load = 1'b0;
    #2;
    chk("kill_req_held", 32'(imem.imem_req), 32'd1);
    chk("kill_addr_held", imem.imem_addr, 32'hC);
    cyc();
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem.imem_ack = 1'b0;
    #2;
    chk("kill_inst", inst, 32'h0000_0013);
    chk("kill_curr", curr_pc_fd, 32'h8);
    chk("kill_next", next_pc_fd, 32'hC);
    cyc();
    do_fetch("redir", 32'h0000_0100, 32'h1111_1111);

    // Redirect in the ack cycle.
    phase_fetch = 1'b1;
    cyc();
    phase_fetch     = 1'b0;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h2222_2222;
    pc_load         = 1'b1;
    pc_load_addr    = 32'h0000_0080;
    cyc();
    imem.imem_ack = 1'b0;
    pc_load       = 1'b0;
    #2;
    chk("ackkill_inst", inst, 32'h0000_0013);
    chk("ackkill_curr", curr_pc_fd, 32'h100);
    chk("ackkill_req", 32'(imem.imem_req), 32'd0);
    cyc();
    do_fetch("ackredir", 32'h0000_0080, 32'h3333_3333);

    // Wrap-around at the top of the address space.
    pc_load      = 1'b1;
    pc_load_addr = 32'hFFFF_FFFC;
    cyc();
    pc_load = 1'b0;
    do_fetch("top", 32'hFFFF_FFFC, 32'h4444_4444);
    do_fetch("wrap", 32'h0, 32'h5555_5555);

    // Redirect together with a strobe in IDLE: old PC fetched, then killed.
    phase_fetch  = 1'b1;
    pc_load      = 1'b1;
    pc_load_addr = 32'h0000_0200;
    cyc();
    phase_fetch     = 1'b0;
    pc_load         = 1'b0;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h7777_7777;
    #2 chk("both_addr", imem.imem_addr, 32'h4);
    cyc();
    imem.imem_ack = 1'b0;
    #2;
    chk("both_inst", inst, 32'h0000_0013);
    chk("both_curr", curr_pc_fd, 32'h0);
    cyc();
    do_fetch("both_next", 32'h0000_0200, 32'h8888_8888);

    // Reset while a read is outstanding.
    phase_fetch = 1'b1;
    cyc();
    phase_fetch = 1'b0;
    #1 chk("mid_req_pre", 32'(imem.imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_req", 32'(imem.imem_req), 32'd0);
    chk("mid_inst", inst, 32'h0000_0013);
    chk("mid_curr", curr_pc_fd, 32'h0);
    chk("mid_next", next_pc_fd, 32'h4);
    chk("mid_stall", 32'(stall_fetch), 32'd0);
    cyc();
    rst_n = 1'b1;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h9999_9999;
    cyc();
    imem.imem_ack = 1'b0;
    #2;
    chk("post_inst", inst, 32'h0000_0013);
    chk("post_req", 32'(imem.imem_req), 32'd0);
    cyc();
    do_fetch("restart", 32'h0, 32'h6666_6666);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
